// File: rtl/mem_access.sv
// Byte-serial load/store engine: runs lb/lh/lw/lbu/lhu/sb/sh/sw as little-endian
// byte transfers on an 8-bit asynchronous SRAM and returns extended load data.
module mem_access #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_n,
    input  logic [7:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done_n,
    output logic        err_n,
    output logic        busy_n,
    output logic [31:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {IDLE, ADDR, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_next;
    logic        is_store, is_signed, err;
    logic [1:0]  last_k, k;
    logic [3:0]  wait_cnt;
    logic [31:0] wbuf, rbuf, load_ext;

    logic [7:0]  op_low;
    logic        op_none, op_multi, dec_store, dec_signed, dec_err;
    logic [1:0]  dec_last_k;

    // Request decode; mem_op is active-low one-hot so work on its inverse.
    always_comb begin
        op_low     = ~mem_op;
        op_none    = (op_low == 8'h00);
        op_multi   = ((op_low & (op_low - 8'd1)) != 8'h00);
        dec_store  = op_low[2] | op_low[1] | op_low[0];
        dec_signed = op_low[7] | op_low[6];
        dec_last_k = 2'd0;
        if (op_low[6] | op_low[3] | op_low[1])
            dec_last_k = 2'd1;
        else if (op_low[5] | op_low[0])
            dec_last_k = 2'd3;
        dec_err = op_multi
                | ((dec_last_k == 2'd1) && addr[0])
                | ((dec_last_k == 2'd3) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        load_ext = rbuf;
        case (last_k)
            2'd0:    load_ext = {{24{is_signed & rbuf[7]}}, rbuf[7:0]};
            2'd1:    load_ext = {{16{is_signed & rbuf[15]}}, rbuf[15:0]};
            default: load_ext = rbuf;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!req_n && !op_none) state_next = dec_err ? DONE : ADDR;
            ADDR:    state_next = STROBE;
            STROBE:  if (wait_cnt == WAIT_LAST) state_next = HOLD;
            HOLD:    state_next = (k == last_k) ? DONE : ADDR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from the state so a reset releases them at once.
    always_comb begin
        sram_ce_n  = !((state == ADDR) || (state == STROBE) || (state == HOLD));
        sram_oe_n  = !((state == STROBE) && !is_store);
        sram_we_n  = !((state == STROBE) && is_store);
        sram_dq_oe = is_store && !sram_ce_n;
        done_n     = (state != DONE);
        err_n      = !((state == DONE) && err);
        busy_n     = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_store  <= 1'b0;
            is_signed <= 1'b0;
            err       <= 1'b0;
            last_k    <= 2'd0;
            k         <= 2'd0;
            wait_cnt  <= 4'd0;
            wbuf      <= 32'h0;
            rbuf      <= 32'h0;
            rdata     <= 32'h0;
            sram_addr <= 32'h0;
            sram_dq_o <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (!req_n && !op_none) begin
                        is_store  <= dec_store;
                        is_signed <= dec_signed;
                        last_k    <= dec_last_k;
                        err       <= dec_err;
                        k         <= 2'd0;
                        wait_cnt  <= 4'd0;
                        wbuf      <= {8'h00, wdata[31:8]};
                        if (!dec_err) begin
                            sram_addr <= addr;
                            if (dec_store) sram_dq_o <= wdata[7:0];
                        end
                    end
                end
                ADDR: wait_cnt <= 4'd0;
                STROBE: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if ((wait_cnt == WAIT_LAST) && !is_store)
                        rbuf[{k, 3'b000} +: 8] <= sram_dq_i;
                end
                HOLD: begin
                    if (k == last_k) begin
                        if (!is_store) rdata <= load_ext;
                    end else begin
                        k         <= k + 2'd1;
                        sram_addr <= sram_addr + 32'd1;
                        if (is_store) sram_dq_o <= wbuf[7:0];
                        wbuf      <= {8'h00, wbuf[31:8]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a behavioural byte-wide SRAM (WAIT_CYCLES=2).
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n, req_n;
    logic [7:0]  mem_op;
    logic [31:0] addr, wdata, rdata, sram_addr;
    logic        done_n, err_n, busy_n, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [7:0]  sram_dq_o, sram_dq_i;

    logic [7:0]  mem [0:1023];

    int checks = 0;
    int failures = 0;

    int cyc, ce_low, we_low, done_cnt, busy_low, dq_bad, done_cyc, done_cyc2;
    logic        done_err;
    logic [31:0] done_rdata;
    logic [7:0]  prev_dq;
    logic [31:0] addr_q [$];

    localparam logic [7:0] OP_LB = 8'h7F, OP_LH = 8'hBF, OP_LW = 8'hDF, OP_LBU = 8'hEF,
                           OP_SH = 8'hFD, OP_SW = 8'hFE;

    mem_access #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done_n(done_n), .err_n(err_n), .busy_n(busy_n),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 8'h00;

    task automatic clear_stats();
        cyc = 0; ce_low = 0; we_low = 0; done_cnt = 0; busy_low = 0; dq_bad = 0;
        done_cyc = -1; done_cyc2 = -1; done_err = 1'bx; done_rdata = 32'hx;
        addr_q.delete();
    endtask

    // One clock: sample at the falling edge, update the SRAM model and statistics.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!sram_ce_n) begin
            ce_low++;
            if (addr_q.size() == 0 || addr_q[$] != sram_addr)
                addr_q.push_back(sram_addr);
            else if (sram_dq_oe && sram_dq_o !== prev_dq)
                dq_bad++;
            prev_dq = sram_dq_o;
        end
        if (!sram_we_n) begin
            we_low++;
            if (sram_dq_oe) mem[sram_addr[9:0]] = sram_dq_o;
        end
        if (!sram_oe_n && sram_dq_oe) dq_bad++;
        if (!busy_n) busy_low++;
        if (!done_n) begin
            done_cnt++;
            if (done_cnt == 1) begin
                done_cyc = cyc; done_err = err_n; done_rdata = rdata;
            end else begin
                done_cyc2 = cyc;
            end
        end
    endtask

    task automatic start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit hold_req);
        @(negedge clk);
        req_n = 1'b0; mem_op = op; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (!hold_req) begin
            req_n = 1'b1; mem_op = 8'hFF; addr = $urandom; wdata = $urandom;
        end
        clear_stats();
    endtask

    task automatic run(input int max_cyc);
        while (done_cnt == 0 && cyc < max_cyc) step();
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL timeout: no done_n within %0d clocks", max_cyc);
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_n = 1'b1; mem_op = 8'hFF; addr = 0; wdata = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({done_n, err_n, busy_n, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 7'b1111110) begin
            failures++;
            $display("FAIL reset_strobes got %b exp 1111110",
                     {done_n, err_n, busy_n, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        checks++;
        if (rdata !== 32'h0 || sram_addr !== 32'h0 || sram_dq_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs got rdata=%h addr=%h dq=%h exp all zero", rdata, sram_addr, sram_dq_o);
        end
        rst_n = 1'b1;
        clear_stats();
        repeat (3) step();
        checks++;
        if (busy_low != 0 || ce_low != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL idle_quiet got busy=%0d ce=%0d done=%0d exp 0", busy_low, ce_low, done_cnt);
        end
    endtask

    task automatic test_lw();
        mem[256] = 8'h78; mem[257] = 8'h56; mem[258] = 8'h34; mem[259] = 8'h12;
        start(OP_LW, 32'h100, 32'h0, 1'b0);
        run(40);
        checks++;
        if (done_rdata !== 32'h12345678) begin
            failures++; $display("FAIL lw_rdata got %h exp 12345678", done_rdata);
        end
        checks++;
        if (done_cyc != 17 || done_err !== 1'b1) begin
            failures++; $display("FAIL lw_timing got clk=%0d err_n=%b exp clk=17 err_n=1", done_cyc, done_err);
        end
        checks++;
        if (addr_q.size() != 4 || addr_q[0] != 32'h100 || addr_q[1] != 32'h101 ||
            addr_q[2] != 32'h102 || addr_q[3] != 32'h103) begin
            failures++; $display("FAIL lw_addr_seq got %0d addresses exp 100..103", addr_q.size());
        end
    endtask

    task automatic test_byte_ops();
        mem[515] = 8'h80;
        start(OP_LB, 32'h203, 32'h0, 1'b0);
        run(20);
        checks++;
        if (done_rdata !== 32'hFFFFFF80 || done_cyc != 5) begin
            failures++; $display("FAIL lb got rdata=%h clk=%0d exp FFFFFF80 clk=5", done_rdata, done_cyc);
        end
        start(OP_LBU, 32'h203, 32'h0, 1'b0);
        run(20);
        checks++;
        if (done_rdata !== 32'h00000080) begin
            failures++; $display("FAIL lbu got %h exp 00000080", done_rdata);
        end
        start(OP_SW, 32'h204, 32'h11223344, 1'b0);
        run(40);
        checks++;
        if (done_rdata !== 32'h00000080 || rdata !== 32'h00000080) begin
            failures++; $display("FAIL sw_rdata_kept got %h exp 00000080", rdata);
        end
        checks++;
        if (mem[516] !== 8'h44 || mem[519] !== 8'h11 || done_cyc != 17) begin
            failures++; $display("FAIL sw_write got %h..%h clk=%0d exp 44..11 clk=17", mem[516], mem[519], done_cyc);
        end
    endtask

    task automatic test_sh();
        start(OP_SH, 32'h10, 32'h0000ABCD, 1'b0);
        run(20);
        checks++;
        if (mem[16] !== 8'hCD || mem[17] !== 8'hAB) begin
            failures++; $display("FAIL sh_data got %h %h exp CD AB", mem[16], mem[17]);
        end
        checks++;
        if (we_low != 4 || dq_bad != 0 || done_cyc != 9) begin
            failures++;
            $display("FAIL sh_strobe got we=%0d dqbad=%0d clk=%0d exp 4 0 9", we_low, dq_bad, done_cyc);
        end
    endtask

    task automatic test_errors();
        start(OP_LW, 32'h102, 32'h0, 1'b0);
        run(10);
        checks++;
        if (done_cyc != 1 || done_err !== 1'b0 || ce_low != 0) begin
            failures++; $display("FAIL misaligned got clk=%0d err_n=%b ce=%0d exp 1 0 0", done_cyc, done_err, ce_low);
        end
        start(8'b11111100, 32'h0, 32'h0, 1'b0);
        run(10);
        checks++;
        if (done_cyc != 1 || done_err !== 1'b0 || ce_low != 0) begin
            failures++; $display("FAIL multi_op got clk=%0d err_n=%b ce=%0d exp 1 0 0", done_cyc, done_err, ce_low);
        end
        @(negedge clk);
        req_n = 1'b0; mem_op = 8'hFF;
        clear_stats();
        repeat (4) step();
        req_n = 1'b1;
        checks++;
        if (busy_low != 0 || done_cnt != 0) begin
            failures++; $display("FAIL no_op got busy=%0d done=%0d exp 0 0", busy_low, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        start(OP_SW, 32'h300, 32'hA1B2C3D4, 1'b0);
        while (addr_q.size() < 2 && cyc < 20) step();
        step();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, busy_n, done_n} !== 6'b111011) begin
            failures++;
            $display("FAIL mid_reset got %b exp 111011", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, busy_n, done_n});
        end
        clear_stats();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        checks++;
        if (done_cnt != 0 || ce_low != 0) begin
            failures++; $display("FAIL mid_reset_quiet got done=%0d ce=%0d exp 0 0", done_cnt, ce_low);
        end
        start(OP_LW, 32'h100, 32'h0, 1'b0);
        run(40);
        checks++;
        if (done_rdata !== 32'h12345678 || done_cyc != 17) begin
            failures++; $display("FAIL post_reset_lw got %h clk=%0d exp 12345678 clk=17", done_rdata, done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        mem[288] = 8'hBC; mem[289] = 8'h9A;
        start(OP_LH, 32'h120, 32'h0, 1'b1);
        while (done_cnt < 2 && cyc < 60) step();
        req_n = 1'b1; mem_op = 8'hFF;
        repeat (3) step();
        checks++;
        if (done_cnt != 2 || done_cyc != 9 || done_cyc2 != 19) begin
            failures++;
            $display("FAIL b2b_timing got done=%0d at %0d,%0d exp 2 at 9,19", done_cnt, done_cyc, done_cyc2);
        end
        checks++;
        if (rdata !== 32'hFFFF9ABC || ce_low != 16) begin
            failures++; $display("FAIL b2b_data got %h ce=%0d exp FFFF9ABC ce=16", rdata, ce_low);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_ops();
        test_sh();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
